// File: rtl/mdl_oob_device.sv
// rtl/mdl_oob_device.sv - device-side SATA OOB sequencer: COMINIT/COMWAKE bursts, ALIGN and SYNC streaming.
// Optional X_RDY after N_SYNC SYNC words is enabled by defining MDL_OOB_XRDY_EN.
module mdl_oob_device #(
    parameter int unsigned UIOOB           = 160,
    parameter int unsigned N_BURST         = 6,
    parameter int unsigned CINIT_IDLE_MULT = 3,
    parameter int unsigned CWAKE_IDLE_MULT = 1,
    parameter int unsigned WAKE_GAP        = 1024,
    parameter int unsigned ALIGN_MIN       = 2048,
    parameter int unsigned RETRY_TIMEOUT   = 65536,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned N_SYNC          = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_comfinish,
    input  logic        i_comreset_det,
    input  logic        i_comwake_dev,
    input  logic        i_comwake_det,
    input  logic        i_link_up,
    output logic        o_burst_en,
    output logic [39:0] o_prim,
    output logic        o_word_strb,
    output logic [3:0]  o_state,
    output logic        o_fail
);

    localparam logic [39:0] ALIGN_P = {10'b0010011100, 10'b0101010101, 10'b0101010101, 10'b0011111010};
    localparam logic [39:0] SYNC_P  = {10'b1010101010, 10'b1010101010, 10'b1010101101, 10'b0011110011};
`ifdef MDL_OOB_XRDY_EN
    localparam logic [39:0] XRDY_P  = {10'b1110100101, 10'b1110100101, 10'b1010101010, 10'b0011110011};
`endif

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CINIT_IDLE = CINIT_IDLE_MULT * UIOOB;
    localparam int unsigned CWAKE_IDLE = CWAKE_IDLE_MULT * UIOOB;
    // One shared cycle timer covers bursts, idles, the wake gap and the retry timeout.
    localparam int unsigned CYC_MAX = max2(max2(max2(UIOOB, CINIT_IDLE), max2(CWAKE_IDLE, WAKE_GAP)), RETRY_TIMEOUT);
    localparam int TMR_W   = (CYC_MAX > 1)   ? $clog2(CYC_MAX)       : 1;
    localparam int BURST_W = (N_BURST > 1)   ? $clog2(N_BURST)       : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WORD_W  = (ALIGN_MIN > 1) ? $clog2(ALIGN_MIN)     : 1;
    localparam int SYNC_W  = (N_SYNC > 1)    ? $clog2(N_SYNC)        : 1;

    localparam logic [TMR_W-1:0]   T_BURST = TMR_W'(UIOOB - 1);
    localparam logic [TMR_W-1:0]   T_CIDLE = TMR_W'(CINIT_IDLE - 1);
    localparam logic [TMR_W-1:0]   T_WIDLE = TMR_W'(CWAKE_IDLE - 1);
    localparam logic [TMR_W-1:0]   T_GAP   = TMR_W'(WAKE_GAP - 1);
    localparam logic [TMR_W-1:0]   T_RETRY = TMR_W'(RETRY_TIMEOUT - 1);
    localparam logic [BURST_W-1:0] B_LAST  = BURST_W'(N_BURST - 1);
    localparam logic [RETRY_W-1:0] R_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [WORD_W-1:0]  W_LAST  = WORD_W'(ALIGN_MIN - 1);
    localparam logic [SYNC_W-1:0]  SY_LAST = SYNC_W'(N_SYNC - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CINIT     = 4'd1,
        S_WAIT_WAKE = 4'd2,
        S_CWAKE     = 4'd3,
        S_WAKE_HOLD = 4'd4,
        S_GAP       = 4'd5,
        S_ALIGN     = 4'd6,
        S_SYNC      = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    state_t             st, st_d;
    logic [TMR_W-1:0]   tmr, tmr_d;
    logic               burst_hi, burst_hi_d;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_d;
    logic [RETRY_W-1:0] retry, retry_d;
    logic [5:0]         bit_cnt, bit_cnt_d;
    logic [WORD_W-1:0]  word_cnt, word_cnt_d;
    logic               align_done, align_done_d;
    logic               seen_wake, seen_wake_d;
    logic [SYNC_W-1:0]  sync_cnt, sync_cnt_d;
    logic [39:0]        prim, prim_d;
    logic               fail, fail_d;
    logic [TMR_W-1:0]   idle_last;
    logic               comreset;
`ifdef MDL_OOB_XRDY_EN
    logic               sync_done, sync_done_d;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st         <= S_IDLE;
            tmr        <= '0;
            burst_hi   <= 1'b0;
            burst_cnt  <= '0;
            retry      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            align_done <= 1'b0;
            seen_wake  <= 1'b0;
            sync_cnt   <= '0;
            prim       <= ALIGN_P;
            fail       <= 1'b0;
`ifdef MDL_OOB_XRDY_EN
            sync_done  <= 1'b0;
`endif
        end else begin
            st         <= st_d;
            tmr        <= tmr_d;
            burst_hi   <= burst_hi_d;
            burst_cnt  <= burst_cnt_d;
            retry      <= retry_d;
            bit_cnt    <= bit_cnt_d;
            word_cnt   <= word_cnt_d;
            align_done <= align_done_d;
            seen_wake  <= seen_wake_d;
            sync_cnt   <= sync_cnt_d;
            prim       <= prim_d;
            fail       <= fail_d;
`ifdef MDL_OOB_XRDY_EN
            sync_done  <= sync_done_d;
`endif
        end
    end

    always_comb begin
        st_d         = st;
        tmr_d        = tmr;
        burst_hi_d   = burst_hi;
        burst_cnt_d  = burst_cnt;
        retry_d      = retry;
        bit_cnt_d    = bit_cnt;
        word_cnt_d   = word_cnt;
        align_done_d = align_done;
        seen_wake_d  = seen_wake;
        sync_cnt_d   = sync_cnt;
        prim_d       = prim;
        fail_d       = fail;
`ifdef MDL_OOB_XRDY_EN
        sync_done_d  = sync_done;
`endif
        idle_last    = (st == S_CINIT) ? T_CIDLE : T_WIDLE;
        comreset     = i_comfinish & i_comreset_det;

        case (st)
            S_CINIT, S_CWAKE: begin
                tmr_d = tmr + 1'b1;
                if (burst_hi) begin
                    if (tmr == T_BURST) begin
                        tmr_d      = '0;
                        burst_hi_d = 1'b0;
                    end
                end else if (tmr == idle_last) begin
                    tmr_d = '0;
                    if (burst_cnt == B_LAST) begin
                        burst_cnt_d = '0;
                        st_d        = (st == S_CINIT) ? S_WAIT_WAKE : S_WAKE_HOLD;
                    end else begin
                        burst_cnt_d = burst_cnt + 1'b1;
                        burst_hi_d  = 1'b1;
                    end
                end
            end
            S_WAIT_WAKE: begin
                tmr_d = tmr + 1'b1;
                if (i_comfinish & i_comwake_dev) begin
                    st_d        = S_CWAKE;
                    tmr_d       = '0;
                    burst_hi_d  = 1'b1;
                    burst_cnt_d = '0;
                end else if (tmr == T_RETRY) begin
                    tmr_d = '0;
                    if (retry == R_MAX) begin
                        st_d   = S_FAIL;
                        fail_d = 1'b1;
                    end else begin
                        retry_d     = retry + 1'b1;
                        st_d        = S_CINIT;
                        burst_hi_d  = 1'b1;
                        burst_cnt_d = '0;
                    end
                end
            end
            S_WAKE_HOLD: begin
                // Host must be seen driving COMWAKE before its release counts.
                if (i_comwake_det) begin
                    seen_wake_d = 1'b1;
                end else if (seen_wake) begin
                    seen_wake_d = 1'b0;
                    st_d        = S_GAP;
                    tmr_d       = '0;
                end
            end
            S_GAP: begin
                tmr_d = tmr + 1'b1;
                if (tmr == T_GAP) begin
                    tmr_d        = '0;
                    st_d         = S_ALIGN;
                    bit_cnt_d    = '0;
                    word_cnt_d   = '0;
                    align_done_d = 1'b0;
                end
            end
            S_ALIGN, S_SYNC: begin
                bit_cnt_d = bit_cnt + 6'd1;
                if (bit_cnt == 6'd39) begin
                    bit_cnt_d = '0;
                    if (st == S_ALIGN) begin
                        if (word_cnt == W_LAST) begin
                            word_cnt_d   = '0;
                            align_done_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt + 1'b1;
                        end
                        if ((align_done || word_cnt == W_LAST) && i_link_up) begin
                            st_d       = S_SYNC;
                            prim_d     = SYNC_P;
                            sync_cnt_d = '0;
                        end
                    end else begin
                        sync_cnt_d = (sync_cnt == SY_LAST) ? '0 : sync_cnt + 1'b1;
`ifdef MDL_OOB_XRDY_EN
                        if (sync_cnt == SY_LAST) begin
                            sync_done_d = 1'b1;
                        end
                        prim_d = (sync_done || sync_cnt == SY_LAST) ? XRDY_P : SYNC_P;
`endif
                    end
                end
            end
            S_IDLE, S_FAIL: begin
            end
            default: st_d = S_IDLE;
        endcase

        // A host COMRESET overrides everything else; retry history survives unless starting from IDLE.
        if (comreset && st != S_CINIT) begin
            st_d         = S_CINIT;
            tmr_d        = '0;
            burst_hi_d   = 1'b1;
            burst_cnt_d  = '0;
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
            align_done_d = 1'b0;
            seen_wake_d  = 1'b0;
            sync_cnt_d   = '0;
            prim_d       = ALIGN_P;
`ifdef MDL_OOB_XRDY_EN
            sync_done_d  = 1'b0;
`endif
            if (st == S_IDLE) begin
                retry_d = '0;
            end
        end
    end

    assign o_burst_en  = (((st == S_CINIT) || (st == S_CWAKE)) && burst_hi) ||
                         (st == S_ALIGN) || (st == S_SYNC);
    assign o_word_strb = ((st == S_ALIGN) || (st == S_SYNC)) && (bit_cnt == 6'd0);
    assign o_prim      = prim;
    assign o_state     = st;
    assign o_fail      = fail;

endmodule

// File: tb/tb_mdl_oob_device.sv
// tb/tb_mdl_oob_device.sv - scoreboard bench for mdl_oob_device (burst timing, ALIGN/SYNC words, retry, COMRESET).
`timescale 1ns/1ps
module tb_mdl_oob_device;

    localparam int UIOOB         = 160;
    localparam int N_BURST       = 6;
    localparam int CINIT_MULT    = 3;
    localparam int CWAKE_MULT    = 1;
    localparam int WAKE_GAP      = 1024;
    localparam int ALIGN_MIN     = 128;
    localparam int RETRY_TIMEOUT = 1000;
    localparam int MAX_RETRY     = 3;
    localparam int N_SYNC        = 16;
`ifdef MDL_OOB_XRDY_EN
    localparam bit XRDY_EN = 1'b1;
`else
    localparam bit XRDY_EN = 1'b0;
`endif

    localparam logic [39:0] ALIGN_P = {10'b0010011100, 10'b0101010101, 10'b0101010101, 10'b0011111010};
    localparam logic [39:0] SYNC_P  = {10'b1010101010, 10'b1010101010, 10'b1010101101, 10'b0011110011};
    localparam logic [39:0] XRDY_P  = {10'b1110100101, 10'b1110100101, 10'b1010101010, 10'b0011110011};

    logic        clk = 1'b0;
    logic        rst, comfinish, comreset_det, comwake_dev, comwake_det, link_up;
    logic        burst_en, word_strb, fail;
    logic [39:0] prim;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;

    typedef struct { int hi; int lo; } burst_t;
    typedef struct { logic [39:0] prim; logic [3:0] st; } word_t;
    burst_t bq[$];
    word_t  wq[$];

    mdl_oob_device #(
        .UIOOB(UIOOB), .N_BURST(N_BURST), .CINIT_IDLE_MULT(CINIT_MULT), .CWAKE_IDLE_MULT(CWAKE_MULT),
        .WAKE_GAP(WAKE_GAP), .ALIGN_MIN(ALIGN_MIN), .RETRY_TIMEOUT(RETRY_TIMEOUT),
        .MAX_RETRY(MAX_RETRY), .N_SYNC(N_SYNC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_comfinish(comfinish), .i_comreset_det(comreset_det),
        .i_comwake_dev(comwake_dev), .i_comwake_det(comwake_det), .i_link_up(link_up),
        .o_burst_en(burst_en), .o_prim(prim), .o_word_strb(word_strb), .o_state(state), .o_fail(fail)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
        $fatal(1);
    end

    task automatic push_bursts(input int lo);
        for (int i = 0; i < N_BURST; i++) bq.push_back('{hi: UIOOB, lo: lo});
    endtask

    task automatic pulse_comreset();
        comfinish = 1'b1; comreset_det = 1'b1;
        @(negedge clk);
        comfinish = 1'b0; comreset_det = 1'b0;
    endtask

    task automatic check_bursts(input string name, input logic [3:0] seq_state, input logic [3:0] fin_state);
        burst_t e;
        int cnt;
        while (bq.size() > 0) begin
            e = bq.pop_front();
            cnt = 0;
            while (!burst_en && cnt < 3000) begin @(negedge clk); cnt++; end
            checks++;
            if (burst_en !== 1'b1) begin errors++; $display("FAIL %s burst start: burst_en=%b, required 1 within 3000 cycles", name, burst_en); end
            cnt = 0;
            while (burst_en && cnt < e.hi + 10) begin cnt++; @(negedge clk); end
            checks++;
            if (cnt !== e.hi) begin errors++; $display("FAIL %s high run: got %0d cycles, required %0d", name, cnt, e.hi); end
            if (bq.size() > 0) begin
                cnt = 0;
                while (!burst_en && cnt < e.lo + 10) begin cnt++; @(negedge clk); end
                checks++;
                if (cnt !== e.lo) begin errors++; $display("FAIL %s low run: got %0d cycles, required %0d", name, cnt, e.lo); end
            end else begin
                repeat (e.lo - 1) @(negedge clk);
                checks++;
                if (state !== seq_state) begin errors++; $display("FAIL %s last idle state: got %0d, required %0d", name, state, seq_state); end
                @(negedge clk);
                checks++;
                if (state !== fin_state) begin errors++; $display("FAIL %s end state: got %0d, required %0d", name, state, fin_state); end
            end
        end
    endtask

    task automatic wake_to_align(input string name);
        int cnt;
        bit strb_seen;
        comfinish = 1'b1; comwake_dev = 1'b1;
        @(negedge clk);
        comfinish = 1'b0; comwake_dev = 1'b0;
        checks++;
        if (state !== 4'd3) begin errors++; $display("FAIL %s cwake entry: state=%0d, required 3", name, state); end
        push_bursts(CWAKE_MULT * UIOOB);
        check_bursts({name, "_cwake"}, 4'd3, 4'd4);
        comwake_det = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (state !== 4'd4 || burst_en !== 1'b0) begin
            errors++; $display("FAIL %s wake hold: state=%0d burst_en=%b, required 4/0", name, state, burst_en);
        end
        comwake_det = 1'b0;
        @(negedge clk);
        cnt = 0; strb_seen = 1'b0;
        while (!burst_en && cnt < WAKE_GAP + 10) begin
            if (word_strb) strb_seen = 1'b1;
            cnt++; @(negedge clk);
        end
        checks++;
        if (cnt !== WAKE_GAP) begin errors++; $display("FAIL %s gap length: got %0d, required %0d", name, cnt, WAKE_GAP); end
        checks++;
        if (strb_seen !== 1'b0) begin errors++; $display("FAIL %s strobe in gap: got 1, required 0", name); end
        checks++;
        if (state !== 4'd6 || word_strb !== 1'b1 || prim !== ALIGN_P) begin
            errors++; $display("FAIL %s align start: state=%0d strb=%b prim=%h, required 6/1/%h", name, state, word_strb, prim, ALIGN_P);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; comfinish = 1'b0; comreset_det = 1'b0; comwake_dev = 1'b0; comwake_det = 1'b0; link_up = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset state: got %0d, required 0", state); end
        checks++; if (burst_en !== 1'b0) begin errors++; $display("FAIL reset burst_en: got %b, required 0", burst_en); end
        checks++; if (word_strb !== 1'b0) begin errors++; $display("FAIL reset strb: got %b, required 0", word_strb); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset fail: got %b, required 0", fail); end
        checks++; if (prim !== ALIGN_P) begin errors++; $display("FAIL reset prim: got %h, required %h", prim, ALIGN_P); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        comfinish = 1'b1; comwake_dev = 1'b1;
        @(negedge clk);
        comfinish = 1'b0; comwake_dev = 1'b0; comreset_det = 1'b1;
        @(negedge clk);
        comreset_det = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || burst_en !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: state=%0d burst_en=%b, required 0/0", state, burst_en);
        end
    endtask

    task automatic test_cominit();
        pulse_comreset();
        checks++;
        if (state !== 4'd1 || burst_en !== 1'b1 || word_strb !== 1'b0) begin
            errors++; $display("FAIL cominit entry: state=%0d burst_en=%b strb=%b, required 1/1/0", state, burst_en, word_strb);
        end
        push_bursts(CINIT_MULT * UIOOB);
        check_bursts("cinit", 4'd1, 4'd2);
    endtask

    task automatic test_wake_align_sync();
        word_t e;
        int cnt;
        int nw;
        nw = ALIGN_MIN + N_SYNC + 8;
        wake_to_align("wake");
        for (int w = 0; w < nw; w++) begin
            if (w < ALIGN_MIN)                    wq.push_back('{prim: ALIGN_P, st: 4'd6});
            else if (XRDY_EN && w >= ALIGN_MIN + N_SYNC) wq.push_back('{prim: XRDY_P, st: 4'd7});
            else                                  wq.push_back('{prim: SYNC_P, st: 4'd7});
        end
        for (int w = 0; w < nw; w++) begin
            e = wq.pop_front();
            if (w > 0) begin
                cnt = 0;
                do begin @(negedge clk); cnt++; end while (!word_strb && cnt < 50);
                checks++;
                if (cnt !== 40) begin errors++; $display("FAIL word %0d spacing: got %0d, required 40", w, cnt); end
            end
            if (w == 100) link_up = 1'b1;
            checks++;
            if (prim !== e.prim) begin errors++; $display("FAIL word %0d prim: got %h, required %h", w, prim, e.prim); end
            checks++;
            if (state !== e.st) begin errors++; $display("FAIL word %0d state: got %0d, required %0d", w, state, e.st); end
        end
    endtask

    task automatic test_retry_fail();
        int cnt;
        repeat (7) @(negedge clk);
        pulse_comreset();
        checks++;
        if (state !== 4'd1 || fail !== 1'b0) begin errors++; $display("FAIL comreset from sync: state=%0d fail=%b, required 1/0", state, fail); end
        for (int k = 0; k <= MAX_RETRY; k++) begin
            push_bursts(CINIT_MULT * UIOOB);
            check_bursts("retry_cinit", 4'd1, 4'd2);
            cnt = 0;
            while (state == 4'd2 && cnt < RETRY_TIMEOUT + 100) begin cnt++; @(negedge clk); end
            checks++;
            if (cnt !== RETRY_TIMEOUT) begin errors++; $display("FAIL retry %0d timeout: got %0d cycles, required %0d", k, cnt, RETRY_TIMEOUT); end
            checks++;
            if (k < MAX_RETRY && state !== 4'd1) begin errors++; $display("FAIL retry %0d reissue: state=%0d, required 1", k, state); end
            else if (k == MAX_RETRY && (state !== 4'd8 || fail !== 1'b1)) begin
                errors++; $display("FAIL retry exhaustion: state=%0d fail=%b, required 8/1", state, fail);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (state !== 4'd8 || fail !== 1'b1 || burst_en !== 1'b0) begin
            errors++; $display("FAIL fail hold: state=%0d fail=%b burst_en=%b, required 8/1/0", state, fail, burst_en);
        end
    endtask

    task automatic test_fail_exit_comreset_align();
        int cnt;
        link_up = 1'b0;
        pulse_comreset();
        checks++;
        if (state !== 4'd1 || fail !== 1'b1) begin errors++; $display("FAIL exit fail: state=%0d fail=%b, required 1/1", state, fail); end
        push_bursts(CINIT_MULT * UIOOB);
        check_bursts("cinit2", 4'd1, 4'd2);
        wake_to_align("wake2");
        for (int w = 1; w < ALIGN_MIN + 5; w++) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!word_strb && cnt < 50);
        end
        checks++;
        if (state !== 4'd6 || prim !== ALIGN_P) begin
            errors++; $display("FAIL align without link: state=%0d prim=%h, required 6/%h", state, prim, ALIGN_P);
        end
        repeat (13) @(negedge clk);
        pulse_comreset();
        checks++;
        if (state !== 4'd1 || burst_en !== 1'b1 || fail !== 1'b1 || prim !== ALIGN_P) begin
            errors++; $display("FAIL comreset in align: state=%0d burst_en=%b fail=%b prim=%h, required 1/1/1/%h", state, burst_en, fail, prim, ALIGN_P);
        end
        push_bursts(CINIT_MULT * UIOOB);
        check_bursts("cinit3", 4'd1, 4'd2);
    endtask

    task automatic test_reset_mid_burst();
        pulse_comreset();
        repeat (30) @(negedge clk);
        checks++;
        if (burst_en !== 1'b1) begin errors++; $display("FAIL mid burst: burst_en=%b, required 1", burst_en); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (burst_en !== 1'b0 || state !== 4'd0 || fail !== 1'b0) begin
            errors++; $display("FAIL reset mid burst: burst_en=%b state=%0d fail=%b, required 0/0/0", burst_en, state, fail);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_cominit();
        test_wake_align_sync();
        test_retry_fail();
        test_fail_exit_comreset_align();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
